// File: rtl/sort_feeder.sv
// Feeds a batch of key/value pairs into the comparator sort chain. After the last pair
// it sends sentinel flush beats, raises done, and waits for chain ready and reader ack.
module sort_feeder #(
    parameter int key_width   = 32,
    parameter int val_width   = 16,
    parameter int count_width = 8,
    parameter int depth       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [key_width-1:0]   s_key,
    input  logic [val_width-1:0]   s_val,
    input  logic                   s_last,
    output logic                   o_en,
    output logic [key_width-1:0]   o_key,
    output logic [val_width-1:0]   o_val,
    output logic                   o_done,
    input  logic                   i_ready,
    input  logic                   i_ack,
    output logic [count_width-1:0] o_count,
    output logic                   o_overflow,
    output logic                   o_complete
);
    // state    | meaning
    // IDLE     | armed, waiting for the first pair of a batch
    // FEED     | forwarding pairs, one beat per transfer
    // FLUSH    | emitting depth-1 all-ones sentinel beats
    // WAIT_RDY | done raised, waiting for the chain to settle
    // DONE     | batch complete, waiting for reader ack
    typedef enum logic [2:0] {IDLE, FEED, FLUSH, WAIT_RDY, DONE} state_t;

    localparam int fc_width = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [fc_width-1:0] flush_len = fc_width'(depth - 1);
    localparam logic [count_width-1:0] count_max = '1;
    localparam state_t after_last = (depth == 1) ? WAIT_RDY : FLUSH;

    state_t                 state, state_nx;
    logic [fc_width-1:0]    flush_cnt, flush_cnt_nx;
    logic                   en_nx, done_nx, complete_nx, overflow_nx;
    logic [key_width-1:0]   key_nx;
    logic [val_width-1:0]   val_nx;
    logic [count_width-1:0] count_nx;
    logic                   xfer;

    assign s_ready = !rst && (state == IDLE || state == FEED);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        en_nx        = 1'b0;
        key_nx       = o_key;
        val_nx       = o_val;
        done_nx      = o_done;
        complete_nx  = o_complete;
        count_nx     = o_count;
        overflow_nx  = o_overflow;
        case (state)
            IDLE, FEED: begin
                if (xfer) begin
                    en_nx  = 1'b1;
                    key_nx = s_key;
                    val_nx = s_val;
                    if (state == IDLE) begin
                        count_nx    = count_width'(1);
                        overflow_nx = 1'b0;
                    end else if (o_count == count_max) begin
                        overflow_nx = 1'b1;
                    end else begin
                        count_nx = o_count + 1'b1;
                    end
                    if (s_last) begin
                        state_nx     = after_last;
                        flush_cnt_nx = flush_len;
                    end else begin
                        state_nx = FEED;
                    end
                end
            end
            FLUSH: begin
                // flush_cnt counts sentinel beats still to emit, including this one
                en_nx        = 1'b1;
                key_nx       = '1;
                val_nx       = '1;
                flush_cnt_nx = flush_cnt - 1'b1;
                if (flush_cnt == fc_width'(1)) state_nx = WAIT_RDY;
            end
            WAIT_RDY: begin
                done_nx = 1'b1;
                if (i_ready) begin
                    state_nx    = DONE;
                    complete_nx = 1'b1;
                end
            end
            DONE: begin
                if (i_ack) begin
                    state_nx    = IDLE;
                    done_nx     = 1'b0;
                    complete_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            o_en       <= 1'b0;
            o_key      <= '1;
            o_val      <= '1;
            o_done     <= 1'b0;
            o_complete <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_cnt  <= flush_cnt_nx;
            o_en       <= en_nx;
            o_key      <= key_nx;
            o_val      <= val_nx;
            o_done     <= done_nx;
            o_complete <= complete_nx;
            o_count    <= count_nx;
            o_overflow <= overflow_nx;
        end
    end
endmodule
